des_key_schedule_seq: RTL and testbench

// - Sequential, multi-slot DES key schedule. Each accepted 64-bit key is expanded into its 16 48-bit

---
 rtl/des_pkg.sv | 55 +++++
 rtl/des_key_rotate_pc2.sv | 25 ++
 rtl/des_key_schedule_seq.sv | 127 ++++++++++++
 tb/tb_des_key_schedule_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: PC-1/PC-2 permutations, rotation schedule and FSM state type.
package des_pkg;

    typedef logic [1:48] subkey_t;

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    // Bit r-1 set means round r rotates by one position, otherwise by two.
    localparam logic [15:0] DES_SHIFT_SCHED = 16'h8103;

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Tables use DES numbering where bit 1 is the MSB of the vector.
    function automatic logic [55:0] des_pc1(input logic [63:0] key);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[6'(55 - i)] = key[6'(64 - PC1_TAB[i])];
        end
        return cd;
    endfunction

    function automatic subkey_t des_pc2(input logic [55:0] cd);
        subkey_t k;
        k = '0;
        for (int j = 0; j < 48; j++) begin
            k[6'(j + 1)] = cd[6'(56 - PC2_TAB[j])];
        end
        return k;
    endfunction

endpackage

// File: rtl/des_key_rotate_pc2.sv
// One key-schedule round step: rotate the C and D halves left by one or two, then apply PC-2.
module des_key_rotate_pc2
    import des_pkg::*;
(
    input  logic [27:0] c,
    input  logic [27:0] d,
    input  logic        shift1,
    output logic [27:0] c_rot,
    output logic [27:0] d_rot,
    output logic [47:0] subkey
);

    always_comb begin
        if (shift1) begin
            c_rot = {c[26:0], c[27]};
            d_rot = {d[26:0], d[27]};
        end else begin
            c_rot = {c[25:0], c[27:26]};
            d_rot = {d[25:0], d[27:26]};
        end
    end

    assign subkey = des_pc2({c_rot, d_rot});

endmodule

// File: rtl/des_key_schedule_seq.sv
// Multi-slot sequential DES key schedule: one round per clock into a subkey file, with a
// registered read port that can return rounds in encrypt or reversed (decrypt) order.
module des_key_schedule_seq
    import des_pkg::*;
#(
    parameter int          NUM_KEYS    = 3,
    parameter logic [15:0] SHIFT_SCHED = DES_SHIFT_SCHED,
    localparam int         SW          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [63:0]         key_in,
    input  logic [SW-1:0]       key_slot,
    output logic                sched_done,
    output logic [NUM_KEYS-1:0] slot_ready,
    input  logic                rd_en,
    input  logic [SW-1:0]       rd_slot,
    input  logic [3:0]          rd_round,
    input  logic                rd_decrypt,
    output logic                subkey_valid,
    output logic [47:0]         subkey_out
);

    localparam logic [SW:0] NUM_SLOTS = NUM_KEYS[SW:0];

    state_t              state;
    state_t              state_next;
    logic [3:0]          round;
    logic [SW-1:0]       slot;
    logic [27:0]         c_half;
    logic [27:0]         d_half;
    logic [27:0]         c_rot;
    logic [27:0]         d_rot;
    logic [47:0]         pc2_out;
    logic [NUM_KEYS-1:0] ready_bits;
    logic                done_p1;
    logic                vld_p1;
    logic [47:0]         subkey_p1;
    subkey_t             key_file [NUM_KEYS][16];

    logic                accept;
    logic                last_round;
    logic                rd_hit;
    logic [3:0]          rd_idx;

    // Out-of-range slots are silently refused while key_ready stays high.
    assign accept     = key_valid && key_ready && ({1'b0, key_slot} < NUM_SLOTS);
    assign last_round = (state == GEN) && (round == 4'd15);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = GEN;
            GEN:     if (round == 4'd15) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        key_ready = (state == IDLE);
    end

    des_key_rotate_pc2 u_rotate (
        .c      (c_half),
        .d      (d_half),
        .shift1 (SHIFT_SCHED[round]),
        .c_rot  (c_rot),
        .d_rot  (d_rot),
        .subkey (pc2_out)
    );

    // The 16 rotations sum to 28, so C/D are back at PC-1(key) when generation ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round      <= '0;
            slot       <= '0;
            c_half     <= '0;
            d_half     <= '0;
            ready_bits <= '0;
            done_p1    <= 1'b0;
        end else begin
            done_p1 <= last_round;
            if (accept) begin
                {c_half, d_half}     <= des_pc1(key_in);
                slot                 <= key_slot;
                round                <= 4'd0;
                ready_bits[key_slot] <= 1'b0;
            end else if (state == GEN) begin
                c_half <= c_rot;
                d_half <= d_rot;
                round  <= round + 4'd1;
                if (last_round) ready_bits[slot] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == GEN) key_file[slot][round] <= pc2_out;
    end

    // Read stage p1: readiness is sampled before this edge's updates, so a reload's accept cycle still reads old data.
    assign rd_idx = rd_decrypt ? (4'd15 - rd_round) : rd_round;
    assign rd_hit = rd_en && ({1'b0, rd_slot} < NUM_SLOTS) && ready_bits[rd_slot];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            subkey_p1 <= '0;
        end else begin
            vld_p1    <= rd_hit;
            subkey_p1 <= rd_hit ? key_file[rd_slot][rd_idx] : '0;
        end
    end

    assign sched_done   = done_p1;
    assign slot_ready   = ready_bits;
    assign subkey_valid = vld_p1;
    assign subkey_out   = subkey_p1;

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Bench for des_key_schedule_seq: table-driven DES schedule model, per-cycle output compare, directed and random loads.
module tb_des_key_schedule_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [63:0] key_in = '0;
    logic [1:0]  key_slot = '0;
    logic        sched_done;
    logic [2:0]  slot_ready;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_slot = '0;
    logic [3:0]  rd_round = '0;
    logic        rd_decrypt = 1'b0;
    logic        subkey_valid;
    logic [47:0] subkey_out;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    des_key_schedule_seq #(.NUM_KEYS(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_in       (key_in),
        .key_slot     (key_slot),
        .sched_done   (sched_done),
        .slot_ready   (slot_ready),
        .rd_en        (rd_en),
        .rd_slot      (rd_slot),
        .rd_round     (rd_round),
        .rd_decrypt   (rd_decrypt),
        .subkey_valid (subkey_valid),
        .subkey_out   (subkey_out)
    );

    localparam int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int ROT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    function automatic logic [15:0][47:0] ref_schedule(input logic [63:0] key);
        logic [55:0]       cd;
        logic [27:0]       c;
        logic [27:0]       d;
        logic [15:0][47:0] ks;
        cd = '0;
        ks = '0;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < ROT[r]; k++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) ks[4'(r)][6'(47 - j)] = cd[6'(56 - PC2[j])];
        end
        return ks;
    endfunction

    // Behavioural model state: readiness per slot, stored schedules, rounds left in generation.
    logic [15:0][47:0] m_sub [4];
    logic [3:0]        m_ready = '0;
    logic [1:0]        m_slot  = '0;
    int                m_left  = 0;
    logic              e_done  = 1'b0;
    logic              e_valid = 1'b0;
    logic [47:0]       e_out   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  <= 0;
            m_ready <= '0;
            e_done  <= 1'b0;
            e_valid <= 1'b0;
            e_out   <= '0;
        end else begin
            if (rd_en && rd_slot < 2'd3 && m_ready[rd_slot]) begin
                e_valid <= 1'b1;
                e_out   <= m_sub[rd_slot][rd_decrypt ? (4'd15 - rd_round) : rd_round];
            end else begin
                e_valid <= 1'b0;
                e_out   <= '0;
            end
            e_done <= (m_left == 1);
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_ready[m_slot] <= 1'b1;
            end else if (key_valid && key_slot < 2'd3) begin
                m_left            <= 16;
                m_slot            <= key_slot;
                m_ready[key_slot] <= 1'b0;
                m_sub[key_slot]   <= ref_schedule(key_in);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_key_ready", {63'd0, key_ready}, {63'd0, m_left == 0});
            check("cyc_sched_done", {63'd0, sched_done}, {63'd0, e_done});
            check("cyc_slot_ready", {61'd0, slot_ready}, {61'd0, m_ready[2:0]});
            check("cyc_subkey_valid", {63'd0, subkey_valid}, {63'd0, e_valid});
            check("cyc_subkey_out", {16'd0, subkey_out}, {16'd0, e_out});
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!key_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("key_ready_timeout", {63'd0, key_ready}, 64'd1);
    endtask

    task automatic wait_done(input string name, input int exp_n);
        int n = 1;
        while (!sched_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, n, exp_n);
    endtask

    task automatic load_key(input logic [63:0] k, input logic [1:0] s);
        wait_ready();
        key_valid = 1'b1;
        key_in    = k;
        key_slot  = s;
        @(negedge clk);
        key_valid = 1'b0;
        key_in    = {$urandom, $urandom};
        wait_done("sched_done_latency", 17);
    endtask

    task automatic do_read(input string name, input logic [1:0] s, input logic [3:0] r, input logic dec,
                           input logic ev, input logic [47:0] eo);
        rd_en      = 1'b1;
        rd_slot    = s;
        rd_round   = r;
        rd_decrypt = dec;
        @(negedge clk);
        rd_en = 1'b0;
        check({name, "_valid"}, {63'd0, subkey_valid}, {63'd0, ev});
        check({name, "_data"}, {16'd0, subkey_out}, {16'd0, eo});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0][47:0] ks;
        logic [63:0]       k3;
        logic [1:0]        p;
        logic [1:0]        s;
        int                cnt_done;
        int                cnt_busy;

        // Pin the model against published DES vectors.
        ks = ref_schedule(64'h133457799BBCDFF1);
        check("model_k1", {16'd0, ks[0]}, 64'h1B02EFFC7072);
        check("model_k16", {16'd0, ks[15]}, 64'hCB3D8B0E17F5);
        ks = ref_schedule(64'hFFFFFFFFFFFFFFFF);
        check("model_ones", {16'd0, ks[5]}, 64'hFFFFFFFFFFFF);

        repeat (3) @(negedge clk);
        check("rst_key_ready", {63'd0, key_ready}, 64'd1);
        check("rst_slot_ready", {61'd0, slot_ready}, 64'd0);
        check("rst_sched_done", {63'd0, sched_done}, 64'd0);
        check("rst_subkey_valid", {63'd0, subkey_valid}, 64'd0);
        check("rst_subkey_out", {16'd0, subkey_out}, 64'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Known-answer load and reads.
        load_key(64'h133457799BBCDFF1, 2'd0);
        do_read("kat_r0", 2'd0, 4'd0, 1'b0, 1'b1, 48'h1B02EFFC7072);
        do_read("kat_r15", 2'd0, 4'd15, 1'b0, 1'b1, 48'hCB3D8B0E17F5);
        do_read("kat_dec_r0", 2'd0, 4'd0, 1'b1, 1'b1, 48'hCB3D8B0E17F5);

        // All-zero and all-one keys.
        load_key(64'h0, 2'd1);
        for (int r = 0; r < 16; r++) do_read("zero_key", 2'd1, 4'(r), 1'b0, 1'b1, 48'h0);
        load_key(64'hFFFFFFFFFFFFFFFF, 2'd2);
        for (int r = 0; r < 16; r++) do_read("ones_key", 2'd2, 4'(r), 1'b0, 1'b1, 48'hFFFFFFFFFFFF);
        do_read("slot0_kept", 2'd0, 4'd0, 1'b0, 1'b1, 48'h1B02EFFC7072);

        // Reload slot 1 with a read of it in the accept cycle, then reads during generation.
        k3 = {$urandom, $urandom};
        key_valid = 1'b1;
        key_in    = k3;
        key_slot  = 2'd1;
        rd_en     = 1'b1;
        rd_slot   = 2'd1;
        rd_round  = 4'd4;
        rd_decrypt = 1'b0;
        @(negedge clk);
        key_valid = 1'b0;
        rd_en     = 1'b0;
        check("reload_old_valid", {63'd0, subkey_valid}, 64'd1);
        check("reload_old_data", {16'd0, subkey_out}, 64'd0);
        do_read("gen_slot", 2'd1, 4'd4, 1'b0, 1'b0, 48'h0);
        do_read("other_slot", 2'd0, 4'd15, 1'b0, 1'b1, 48'hCB3D8B0E17F5);
        wait_done("reload_done", 15);
        ks = ref_schedule(k3);
        do_read("reload_new", 2'd1, 4'd0, 1'b0, 1'b1, ks[0]);

        // Reset in the middle of generation (round 7).
        key_valid = 1'b1;
        key_in    = {$urandom, $urandom};
        key_slot  = 2'd2;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("midrst_key_ready", {63'd0, key_ready}, 64'd1);
        check("midrst_slot_ready", {61'd0, slot_ready}, 64'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        do_read("midrst_read0", 2'd0, 4'd0, 1'b0, 1'b0, 48'h0);
        do_read("midrst_read1", 2'd1, 4'd3, 1'b1, 1'b0, 48'h0);

        // key_valid held across two schedules gives exactly two accepts.
        cnt_done  = 0;
        key_valid = 1'b1;
        key_in    = {$urandom, $urandom};
        key_slot  = 2'd0;
        for (int i = 0; i < 54; i++) begin
            @(negedge clk);
            if (sched_done) cnt_done++;
            if (i == 33) key_valid = 1'b0;
        end
        check("hold_done_count", cnt_done, 2);

        // Out-of-range slot is ignored.
        cnt_done  = 0;
        cnt_busy  = 0;
        key_valid = 1'b1;
        key_slot  = 2'd3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sched_done) cnt_done++;
            if (!key_ready) cnt_busy++;
        end
        key_valid = 1'b0;
        check("bad_slot_done", cnt_done, 0);
        check("bad_slot_busy", cnt_busy, 0);

        // Random keys into random slots; the previous slot is read in both orders meanwhile.
        p = 2'd0;
        for (int it = 0; it < 1000; it++) begin
            s = 2'($urandom_range(0, 2));
            if (s == p) s = (s == 2'd2) ? 2'd0 : s + 2'd1;
            wait_ready();
            key_in   = {$urandom, $urandom};
            key_slot = s;
            rd_en    = 1'b1;
            rd_slot  = p;
            for (int k = 0; k < 32; k++) begin
                key_valid  = (k == 0);
                rd_round   = 4'(k % 16);
                rd_decrypt = (k >= 16);
                @(negedge clk);
                if (k == 0) key_in = {$urandom, $urandom};
            end
            key_valid = 1'b0;
            rd_en     = 1'b0;
            p = s;
        end
        wait_ready();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
